// File: rtl/issue_queue_age.sv
// issue_queue_age: age-ordered issue queue between dispatch and execution pipes (optional macro IQ_AGE_ORDER_EN).
// Latency: dispatch-to-issue and wakeup-to-issue 1 cycle; issue outputs combinational from registered state.
// Backpressure: disp_ready_o only when a full dispatch group fits; issue_stall_i idles a port for the cycle.
module issue_queue_age #(
    parameter int DEPTH          = 16,
    parameter int DISPATCH_WIDTH = 4,
    parameter int ISSUE_WIDTH    = 3,
    parameter int WAKEUP_WIDTH   = 3,
    parameter int TAG_WIDTH      = 6,
    parameter int PAYLOAD_WIDTH  = 64,
    parameter int FU_TYPES       = 4
) (
    input  logic                                     clock_i,
    input  logic                                     reset_i,
    input  logic                                     flush_i,
    input  logic [DISPATCH_WIDTH-1:0]                disp_valid_i,
    input  logic [DISPATCH_WIDTH*PAYLOAD_WIDTH-1:0]  disp_payload_i,
    input  logic [DISPATCH_WIDTH*FU_TYPES-1:0]       disp_fu_i,
    input  logic [DISPATCH_WIDTH*TAG_WIDTH-1:0]      disp_rs1_tag_i,
    input  logic [DISPATCH_WIDTH*TAG_WIDTH-1:0]      disp_rs2_tag_i,
    input  logic [DISPATCH_WIDTH-1:0]                disp_rs1_rdy_i,
    input  logic [DISPATCH_WIDTH-1:0]                disp_rs2_rdy_i,
    output logic                                     disp_ready_o,
    input  logic [WAKEUP_WIDTH-1:0]                  wakeup_valid_i,
    input  logic [WAKEUP_WIDTH*TAG_WIDTH-1:0]        wakeup_tag_i,
    input  logic [ISSUE_WIDTH*FU_TYPES-1:0]          port_fu_mask_i,
    input  logic [ISSUE_WIDTH-1:0]                   issue_stall_i,
    output logic [ISSUE_WIDTH-1:0]                   issue_valid_o,
    output logic [ISSUE_WIDTH*PAYLOAD_WIDTH-1:0]     issue_payload_o,
    output logic [ISSUE_WIDTH*FU_TYPES-1:0]          issue_fu_o,
    output logic [$clog2(DEPTH+1)-1:0]               free_count_o
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0]         rdy1_q, rdy1_d;
    logic [DEPTH-1:0]         rdy2_q, rdy2_d;
    logic [TAG_WIDTH-1:0]     tag1_q    [DEPTH];
    logic [TAG_WIDTH-1:0]     tag2_q    [DEPTH];
    logic [FU_TYPES-1:0]      fu_q      [DEPTH];
    logic [PAYLOAD_WIDTH-1:0] payload_q [DEPTH];
    logic [CW-1:0]            free_count_q, free_count_d;
    logic [DEPTH-1:0]         issue_grant;
    logic [DEPTH-1:0]         alloc_oh  [DISPATCH_WIDTH];
    logic                     kill;
    logic                     accept;
`ifdef IQ_AGE_ORDER_EN
    logic [DEPTH-1:0]         older_q   [DEPTH];
    logic [DEPTH-1:0]         older_d   [DEPTH];
`endif

    function automatic logic wake_hit(input logic [TAG_WIDTH-1:0]              tag,
                                      input logic [WAKEUP_WIDTH-1:0]           vld,
                                      input logic [WAKEUP_WIDTH*TAG_WIDTH-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < WAKEUP_WIDTH; w++) begin
            if (vld[w] && (tags[w*TAG_WIDTH +: TAG_WIDTH] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign kill         = reset_i | flush_i;
    assign free_count_o = free_count_q;
    assign disp_ready_o = (free_count_q >= CW'(DISPATCH_WIDTH));
    assign accept       = disp_ready_o & ~kill;

    // Ports resolve in order; each unstalled port takes the best remaining eligible entry its FU mask allows.
    always_comb begin
        logic [DEPTH-1:0] elig;
        logic [DEPTH-1:0] taken;
        logic [DEPTH-1:0] cand;
        logic             found;
`ifdef IQ_AGE_ORDER_EN
        logic             blocked;
`endif
        elig            = valid_q & rdy1_q & rdy2_q;
        taken           = '0;
        issue_valid_o   = '0;
        issue_payload_o = '0;
        issue_fu_o      = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                cand[i] = elig[i] & ~taken[i] &
                          (|(fu_q[i] & port_fu_mask_i[p*FU_TYPES +: FU_TYPES]));
            end
            if (!kill && !issue_stall_i[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
`ifdef IQ_AGE_ORDER_EN
                    // An entry wins only if no other candidate is older than it.
                    blocked = 1'b0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (cand[j] && older_q[j][i]) blocked = 1'b1;
                    end
                    if (!found && cand[i] && !blocked) begin
`else
                    if (!found && cand[i]) begin
`endif
                        found                                           = 1'b1;
                        taken[i]                                        = 1'b1;
                        issue_payload_o[p*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = payload_q[i];
                        issue_fu_o[p*FU_TYPES +: FU_TYPES]              = fu_q[i];
                    end
                end
            end
            issue_valid_o[p] = found;
        end
        issue_grant = taken;
    end

    // Allocate valid lanes in lane order to the lowest free entries; entries issuing now count as free.
    always_comb begin
        logic [DEPTH-1:0] free_v;
        logic             found;
        free_v = ~valid_q | issue_grant;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            alloc_oh[l] = '0;
            found       = 1'b0;
            if (accept && disp_valid_i[l]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!found && free_v[i]) begin
                        alloc_oh[l][i] = 1'b1;
                        free_v[i]      = 1'b0;
                        found          = 1'b1;
                    end
                end
            end
        end
    end

    // Next valid/ready state and exact occupancy; newly written sources see the live wakeup bus.
    always_comb begin
        int n_acc;
        int n_iss;
        valid_d = valid_q & ~issue_grant;
        rdy1_d  = rdy1_q;
        rdy2_d  = rdy2_q;
        n_acc   = 0;
        n_iss   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wake_hit(tag1_q[i], wakeup_valid_i, wakeup_tag_i)) rdy1_d[i] = 1'b1;
            if (wake_hit(tag2_q[i], wakeup_valid_i, wakeup_tag_i)) rdy2_d[i] = 1'b1;
            if (issue_grant[i]) n_iss++;
        end
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (|alloc_oh[l]) n_acc++;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[l][i]) begin
                    valid_d[i] = 1'b1;
                    rdy1_d[i]  = disp_rs1_rdy_i[l] |
                                 wake_hit(disp_rs1_tag_i[l*TAG_WIDTH +: TAG_WIDTH], wakeup_valid_i, wakeup_tag_i);
                    rdy2_d[i]  = disp_rs2_rdy_i[l] |
                                 wake_hit(disp_rs2_tag_i[l*TAG_WIDTH +: TAG_WIDTH], wakeup_valid_i, wakeup_tag_i);
                end
            end
        end
        free_count_d = free_count_q - CW'(n_acc) + CW'(n_iss);
    end

    // Control state register; reset and flush both empty the queue.
    always_ff @(posedge clock_i) begin
        if (kill) begin
            valid_q      <= '0;
            rdy1_q       <= '0;
            rdy2_q       <= '0;
            free_count_q <= CW'(DEPTH);
        end else begin
            valid_q      <= valid_d;
            rdy1_q       <= rdy1_d;
            rdy2_q       <= rdy2_d;
            free_count_q <= free_count_d;
        end
    end

    // Entry datapath: captured on allocation only, meaningful only while the entry is valid.
    always_ff @(posedge clock_i) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[l][i]) begin
                    tag1_q[i]    <= disp_rs1_tag_i[l*TAG_WIDTH +: TAG_WIDTH];
                    tag2_q[i]    <= disp_rs2_tag_i[l*TAG_WIDTH +: TAG_WIDTH];
                    fu_q[i]      <= disp_fu_i[l*FU_TYPES +: FU_TYPES];
                    payload_q[i] <= disp_payload_i[l*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
                end
            end
        end
    end

`ifdef IQ_AGE_ORDER_EN
    // New entries become younger than every survivor and every lower lane written alongside them.
    always_comb begin
        logic [DEPTH-1:0] seen;
        older_d = older_q;
        seen    = valid_q & ~issue_grant;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[l][i]) begin
                    older_d[i] = '0;
                    for (int j = 0; j < DEPTH; j++) older_d[j][i] = seen[j];
                end
            end
            seen = seen | alloc_oh[l];
        end
    end

    // Age matrix register.
    always_ff @(posedge clock_i) begin
        if (kill) begin
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else begin
            older_q <= older_d;
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue_age.sv
module tb_issue_queue_age;
    localparam int DEPTH = 16, DW = 4, IW = 3, WW = 3, TW = 6, PW = 64, FT = 4;
`ifdef IQ_AGE_ORDER_EN
    localparam bit AGE_MODE = 1'b1;
`else
    localparam bit AGE_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush;
    logic [DW-1:0]     disp_valid;
    logic [DW*PW-1:0]  disp_payload;
    logic [DW*FT-1:0]  disp_fu;
    logic [DW*TW-1:0]  disp_rs1_tag, disp_rs2_tag;
    logic [DW-1:0]     disp_rs1_rdy, disp_rs2_rdy;
    logic              disp_ready;
    logic [WW-1:0]     wakeup_valid;
    logic [WW*TW-1:0]  wakeup_tag;
    logic [IW*FT-1:0]  port_fu_mask;
    logic [IW-1:0]     issue_stall;
    logic [IW-1:0]     issue_valid;
    logic [IW*PW-1:0]  issue_payload;
    logic [IW*FT-1:0]  issue_fu;
    logic [4:0]        free_count;

    issue_queue_age dut (
        .clock_i(clk), .reset_i(reset), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_payload_i(disp_payload), .disp_fu_i(disp_fu),
        .disp_rs1_tag_i(disp_rs1_tag), .disp_rs2_tag_i(disp_rs2_tag),
        .disp_rs1_rdy_i(disp_rs1_rdy), .disp_rs2_rdy_i(disp_rs2_rdy),
        .disp_ready_o(disp_ready),
        .wakeup_valid_i(wakeup_valid), .wakeup_tag_i(wakeup_tag),
        .port_fu_mask_i(port_fu_mask), .issue_stall_i(issue_stall),
        .issue_valid_o(issue_valid), .issue_payload_o(issue_payload), .issue_fu_o(issue_fu),
        .free_count_o(free_count)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: a set of slots, each with a dispatch sequence number for age.
    bit             mv  [DEPTH];
    int             ms  [DEPTH];
    bit             mr1 [DEPTH], mr2 [DEPTH];
    int             mt1 [DEPTH], mt2 [DEPTH];
    logic [FT-1:0]  mf  [DEPTH];
    logic [PW-1:0]  mp  [DEPTH];
    int             seq_ctr = 0;
    int             grant [IW];
    logic [IW-1:0]  exp_iv;
    logic [IW*PW-1:0] exp_pay;
    logic [IW*FT-1:0] exp_fu;
    logic [4:0]     exp_fc;
    logic           exp_dr;

    function automatic bit on_bus(input int tag);
        for (int w = 0; w < WW; w++)
            if (wakeup_valid[w] && int'(wakeup_tag[w*TW +: TW]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_eval();
        bit taken [DEPTH];
        int nvalid;
        nvalid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            taken[i] = 1'b0;
            if (mv[i]) nvalid++;
        end
        exp_fc  = 5'(DEPTH - nvalid);
        exp_dr  = (DEPTH - nvalid) >= DW;
        exp_iv  = '0;
        exp_pay = '0;
        exp_fu  = '0;
        for (int p = 0; p < IW; p++) begin
            grant[p] = -1;
            if (!reset && !flush && !issue_stall[p]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mv[i] && mr1[i] && mr2[i] && !taken[i] &&
                        (mf[i] & port_fu_mask[p*FT +: FT]) != 0) begin
                        if (grant[p] < 0) grant[p] = i;
                        else if (AGE_MODE && ms[i] < ms[grant[p]]) grant[p] = i;
                    end
                end
                if (grant[p] >= 0) begin
                    taken[grant[p]]        = 1'b1;
                    exp_iv[p]              = 1'b1;
                    exp_pay[p*PW +: PW]    = mp[grant[p]];
                    exp_fu[p*FT +: FT]     = mf[grant[p]];
                end
            end
        end
    endtask

    task automatic model_commit();
        int slot;
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
            return;
        end
        for (int p = 0; p < IW; p++) if (grant[p] >= 0) mv[grant[p]] = 1'b0;
        if (exp_dr) begin
            for (int l = 0; l < DW; l++) begin
                if (disp_valid[l]) begin
                    slot = -1;
                    for (int i = DEPTH-1; i >= 0; i--) if (!mv[i]) slot = i;
                    mv[slot]  = 1'b1;
                    ms[slot]  = seq_ctr++;
                    mt1[slot] = int'(disp_rs1_tag[l*TW +: TW]);
                    mt2[slot] = int'(disp_rs2_tag[l*TW +: TW]);
                    mr1[slot] = disp_rs1_rdy[l] | on_bus(mt1[slot]);
                    mr2[slot] = disp_rs2_rdy[l] | on_bus(mt2[slot]);
                    mf[slot]  = disp_fu[l*FT +: FT];
                    mp[slot]  = disp_payload[l*PW +: PW];
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (mv[i] && on_bus(mt1[i])) mr1[i] = 1'b1;
            if (mv[i] && on_bus(mt2[i])) mr2[i] = 1'b1;
        end
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0; disp_valid = '0; wakeup_valid = '0; issue_stall = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1'b1; tick(); reset = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [FT-1:0] fu, input logic [PW-1:0] pay,
                            input int t1, input bit r1, input int t2, input bit r2);
        disp_fu[l*FT +: FT]      = fu;
        disp_payload[l*PW +: PW] = pay;
        disp_rs1_tag[l*TW +: TW] = TW'(t1);
        disp_rs2_tag[l*TW +: TW] = TW'(t2);
        disp_rs1_rdy[l]          = r1;
        disp_rs2_rdy[l]          = r2;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; issue_stall = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b000) $display("FAIL reset_iv_during got %b want 000", issue_valid); else passed++;
        tick(); reset = 1'b0;
        @(negedge clk);
        checks++; if (free_count !== 5'd16) $display("FAIL reset_free got %0d want 16", free_count); else passed++;
        checks++; if (disp_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", disp_ready); else passed++;
        checks++; if (issue_valid !== 3'b000) $display("FAIL reset_iv got %b want 000", issue_valid); else passed++;
    endtask

    task automatic test_dispatch_issue();
        do_reset();
        port_fu_mask = {3{4'b0001}};
        for (int l = 0; l < DW; l++) set_lane(l, 4'b0001, 64'd100 + 64'(l), 0, 1'b1, 0, 1'b1);
        disp_valid = 4'hF;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b000) $display("FAIL disp_same_cycle got %b want 000", issue_valid); else passed++;
        tick(); disp_valid = '0;
        @(negedge clk);
        checks++; if (free_count !== 5'd12) $display("FAIL disp_free got %0d want 12", free_count); else passed++;
        checks++; if (issue_valid !== 3'b111) $display("FAIL disp_iv got %b want 111", issue_valid); else passed++;
        checks++; if (issue_payload !== {64'd102, 64'd101, 64'd100})
            $display("FAIL disp_pay got %h want 102/101/100", issue_payload); else passed++;
        tick(); @(negedge clk);
        checks++; if (issue_valid !== 3'b001) $display("FAIL disp_iv2 got %b want 001", issue_valid); else passed++;
        checks++; if (issue_payload !== {128'd0, 64'd103}) $display("FAIL disp_pay2 got %h want 103", issue_payload); else passed++;
        checks++; if (free_count !== 5'd15) $display("FAIL disp_free2 got %0d want 15", free_count); else passed++;
        tick(); @(negedge clk);
        checks++; if (free_count !== 5'd16) $display("FAIL disp_free3 got %0d want 16", free_count); else passed++;
    endtask

    task automatic test_full_backpressure();
        do_reset();
        port_fu_mask = {3{4'b0001}};
        for (int g = 0; g < 3; g++) begin
            for (int l = 0; l < DW; l++) set_lane(l, 4'b0001, 64'(200 + g*4 + l), 7, 1'b0, 0, 1'b1);
            disp_valid = 4'hF; tick();
        end
        set_lane(0, 4'b0001, 64'd777, 9, 1'b0, 0, 1'b1);
        disp_valid = 4'b0001; tick(); disp_valid = '0;
        @(negedge clk);
        checks++; if (free_count !== 5'd3) $display("FAIL full_free got %0d want 3", free_count); else passed++;
        checks++; if (disp_ready !== 1'b0) $display("FAIL full_ready got %b want 0", disp_ready); else passed++;
        for (int l = 0; l < DW; l++) set_lane(l, 4'b0001, 64'd999, 0, 1'b1, 0, 1'b1);
        disp_valid = 4'hF; tick(); disp_valid = '0;
        @(negedge clk);
        checks++; if (free_count !== 5'd3) $display("FAIL full_drop_free got %0d want 3", free_count); else passed++;
        checks++; if (issue_valid !== 3'b000) $display("FAIL full_drop_iv got %b want 000", issue_valid); else passed++;
        wakeup_valid = 3'b001; wakeup_tag = {12'd0, 6'd9}; tick(); wakeup_valid = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'd777)
            $display("FAIL full_one_issue got %b/%0d want 001/777", issue_valid, issue_payload[63:0]); else passed++;
        tick(); @(negedge clk);
        checks++; if (free_count !== 5'd4) $display("FAIL full_free4 got %0d want 4", free_count); else passed++;
        checks++; if (disp_ready !== 1'b1) $display("FAIL full_ready4 got %b want 1", disp_ready); else passed++;
    endtask

    task automatic test_wakeup_bypass();
        do_reset();
        port_fu_mask = {3{4'b0001}};
        set_lane(0, 4'b0001, 64'd55, 5, 1'b0, 0, 1'b1);
        disp_valid = 4'b0001; wakeup_valid = 3'b001; wakeup_tag = {12'd0, 6'd5};
        tick(); disp_valid = '0; wakeup_valid = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'd55)
            $display("FAIL bypass got %b/%0d want 001/55", issue_valid, issue_payload[63:0]); else passed++;
        tick();
        set_lane(0, 4'b0001, 64'd66, 5, 1'b0, 0, 1'b1);
        disp_valid = 4'b0001; tick(); disp_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (issue_valid !== 3'b000) $display("FAIL wait_tag cyc %0d got %b want 000", k, issue_valid); else passed++;
            tick();
        end
        wakeup_valid = 3'b100; wakeup_tag = {6'd5, 12'd0}; tick(); wakeup_valid = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'd66)
            $display("FAIL late_wake got %b/%0d want 001/66", issue_valid, issue_payload[63:0]); else passed++;
        tick();
    endtask

    task automatic test_fu_masks();
        do_reset();
        port_fu_mask = {4'b1001, 4'b0101, 4'b0011};
        set_lane(0, 4'b1000, 64'd200, 0, 1'b1, 0, 1'b1);
        set_lane(1, 4'b0100, 64'd201, 0, 1'b1, 0, 1'b1);
        set_lane(2, 4'b0010, 64'd202, 0, 1'b1, 0, 1'b1);
        set_lane(3, 4'b0001, 64'd203, 0, 1'b1, 0, 1'b1);
        disp_valid = 4'hF; tick(); disp_valid = '0;
        @(negedge clk);
        checks++; if (issue_payload !== {64'd200, 64'd201, 64'd202} || issue_valid !== 3'b111)
            $display("FAIL mask_pay got %b/%h want 111/div,mul,br", issue_valid, issue_payload); else passed++;
        checks++; if (issue_fu !== {4'b1000, 4'b0100, 4'b0010})
            $display("FAIL mask_fu got %h want 842", issue_fu); else passed++;
        tick(); @(negedge clk);
        checks++; if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'd203)
            $display("FAIL mask_alu got %b/%0d want 001/203", issue_valid, issue_payload[63:0]); else passed++;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        port_fu_mask = {3{4'b0001}};
        for (int l = 0; l < 3; l++) set_lane(l, 4'b0001, 64'd300 + 64'(l), 0, 1'b1, 0, 1'b1);
        disp_valid = 4'b0111; issue_stall = 3'b010; tick(); disp_valid = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b101 || issue_payload !== {64'd301, 64'd0, 64'd300})
            $display("FAIL stall got %b/%h want 101/301,0,300", issue_valid, issue_payload); else passed++;
        tick(); issue_stall = '0;
        @(negedge clk);
        checks++; if (issue_valid !== 3'b001 || issue_payload[63:0] !== 64'd302)
            $display("FAIL stall_rest got %b/%0d want 001/302", issue_valid, issue_payload[63:0]); else passed++;
        checks++; if (free_count !== 5'd15) $display("FAIL stall_free got %0d want 15", free_count); else passed++;
        tick();
    endtask

    task automatic test_flush_reset();
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            port_fu_mask = {3{4'b0001}};
            issue_stall = 3'b111;
            for (int l = 0; l < DW; l++) set_lane(l, 4'b0001, 64'd400 + 64'(l), 0, 1'b1, 0, 1'b1);
            disp_valid = 4'hF; tick(); tick();
            disp_valid = 4'b0001; tick(); disp_valid = '0;
            @(negedge clk);
            checks++; if (free_count !== 5'd7) $display("FAIL kill_pre_free m%0d got %0d want 7", mode, free_count); else passed++;
            issue_stall = '0; disp_valid = 4'hF;
            if (mode == 0) flush = 1'b1; else reset = 1'b1;
            @(negedge clk);
            checks++; if (issue_valid !== 3'b000) $display("FAIL kill_iv m%0d got %b want 000", mode, issue_valid); else passed++;
            tick(); idle();
            @(negedge clk);
            checks++; if (free_count !== 5'd16 || issue_valid !== 3'b000)
                $display("FAIL kill_after m%0d got %0d/%b want 16/000", mode, free_count, issue_valid); else passed++;
        end
    endtask

    task automatic test_random();
        idle(); reset = 1'b1;
        for (int p = 0; p < IW; p++) port_fu_mask[p*FT +: FT] = 4'($urandom_range(1, 15));
        @(negedge clk); model_eval(); model_commit(); tick();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 99) == 0);
            disp_valid = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'b0;
            for (int l = 0; l < DW; l++)
                set_lane(l, 4'(1 << $urandom_range(0, 3)), {$urandom, $urandom},
                         $urandom_range(0, 7), ($urandom_range(0, 2) == 0),
                         $urandom_range(0, 7), ($urandom_range(0, 1) == 0));
            wakeup_valid = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b0;
            for (int w = 0; w < WW; w++) wakeup_tag[w*TW +: TW] = 6'($urandom_range(0, 7));
            issue_stall = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
            @(negedge clk);
            model_eval();
            checks++;
            if ({issue_valid, issue_payload, issue_fu, free_count, disp_ready} !==
                {exp_iv, exp_pay, exp_fu, exp_fc, exp_dr})
                $display("FAIL rand cyc %0d got iv=%b fc=%0d rdy=%b pay=%h fu=%h want iv=%b fc=%0d rdy=%b pay=%h fu=%h",
                         cyc, issue_valid, free_count, disp_ready, issue_payload, issue_fu,
                         exp_iv, exp_fc, exp_dr, exp_pay, exp_fu);
            else passed++;
            model_commit();
            tick();
        end
        idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle();
        disp_payload = '0; disp_fu = '0; disp_rs1_tag = '0; disp_rs2_tag = '0;
        disp_rs1_rdy = '0; disp_rs2_rdy = '0; wakeup_tag = '0; port_fu_mask = {3{4'b0001}};
        #1;
        test_reset();
        test_dispatch_issue();
        test_full_backpressure();
        test_wakeup_bypass();
        test_fu_masks();
        test_stall();
        test_flush_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
